// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the writeback stage: default widths and the MEM/WB
// bus field offsets. The mem2wb packer and the wb_regfile unpacker both use
// these constants, so the two ends of the pipeline register cannot drift.
package wb_regfile_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 6;
    localparam int BW_DEF = 2 + AW_DEF + 2 * DW_DEF;

    // MEM/WB bus layout, LSB first: RegWrite, MemToReg, writeReg, alu_out, dmOut
    localparam int RW_BIT  = 0;
    localparam int M2R_BIT = 1;
    localparam int WR_LSB  = 2;
    localparam int ALU_LSB = 8;
    localparam int DM_LSB  = 40;

    // Builds a MEM/WB bus word from its fields (used by the mem2wb packer).
    function automatic logic [BW_DEF-1:0] mem2wb_pack(
        input logic              reg_write,
        input logic              mem_to_reg,
        input logic [AW_DEF-1:0] write_reg,
        input logic [DW_DEF-1:0] alu_out,
        input logic [DW_DEF-1:0] dm_out
    );
        logic [BW_DEF-1:0] bus;
        bus                     = '0;
        bus[RW_BIT]             = reg_write;
        bus[M2R_BIT]            = mem_to_reg;
        bus[WR_LSB +: AW_DEF]   = write_reg;
        bus[ALU_LSB +: DW_DEF]  = alu_out;
        bus[DM_LSB +: DW_DEF]   = dm_out;
        return bus;
    endfunction

endpackage

// File: rtl/wb_regfile_regfile_2r1w.sv
// regfile_2r1w: architectural register array with two combinational read
// ports and one clocked write port. Register 0 is hard-wired to zero, a
// write-port hit bypasses the array on both read ports, and clr_n clears
// the whole array asynchronously.
module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data
);

    localparam int NREGS = 2 ** AW;

    logic [DW-1:0] regs [NREGS];

    // Commit the write on the rising edge; reset wipes every entry and wins
    // over a write presented in the same cycle. The caller never asserts we
    // for address 0, so entry 0 stays at its reset value of zero.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read port A: same-cycle bypass first, then zero register, then array.
    always_comb begin
        rs_data = '0;
        if (we && (rs_addr == wr_addr)) begin
            rs_data = wr_data;
        end else if (rs_addr != '0) begin
            rs_data = regs[rs_addr];
        end
    end

    // Read port B: identical rule, evaluated independently of port A.
    always_comb begin
        rt_data = '0;
        if (we && (rt_addr == wr_addr)) begin
            rt_data = wr_data;
        end else if (rt_addr != '0) begin
            rt_data = regs[rt_addr];
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage. Unpacks the MEM/WB bus, selects the result
// (ALU or data memory), commits it to the register file and drives the
// forwarding tap for the EX-stage hazard unit.
// Optional build macro WB_TRACE_EN adds retire_cnt (committed-write counter)
// and last_wr ({writeReg, wb_data} of the most recent commit).
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int BW = 2 + AW + 2 * DW
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic [BW-1:0] wb_bus,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic          fwd_valid,
    output logic [AW-1:0] fwd_reg,
    output logic [DW-1:0] fwd_data
`ifdef WB_TRACE_EN
    ,
    output logic [31:0]      retire_cnt,
    output logic [AW+DW-1:0] last_wr
`endif
);

    logic          reg_write;
    logic          mem_to_reg;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] alu_out;
    logic [DW-1:0] dm_out;
    logic [DW-1:0] wb_data;
    logic          we;

    // Bus unpacking, result mux and write enable. An all-zero bus (bubble)
    // has RegWrite=0 and therefore never writes. Because we is gated by
    // RegWrite first, unknown data fields on a non-writing bus cannot reach
    // the array.
    always_comb begin
        reg_write  = wb_bus[RW_BIT];
        mem_to_reg = wb_bus[M2R_BIT];
        write_reg  = wb_bus[WR_LSB +: AW];
        alu_out    = wb_bus[ALU_LSB +: DW];
        dm_out     = wb_bus[DM_LSB +: DW];
        wb_data    = mem_to_reg ? dm_out : alu_out;
        we         = reg_write && (write_reg != '0);
    end

    // Forwarding tap: mirrors the write port in the same cycle.
    always_comb begin
        fwd_valid = we;
        fwd_reg   = write_reg;
        fwd_data  = wb_data;
    end

    regfile_2r1w #(
        .DW(DW),
        .AW(AW)
    ) u_regfile (
        .clk    (clk),
        .clr_n  (clr_n),
        .we     (we),
        .wr_addr(write_reg),
        .wr_data(wb_data),
        .rs_addr(rs_addr),
        .rt_addr(rt_addr),
        .rs_data(rs_data),
        .rt_data(rt_data)
    );

`ifdef WB_TRACE_EN
    // Retirement trace: count commits (wrapping) and remember the last one.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            retire_cnt <= '0;
            last_wr    <= '0;
        end else if (we) begin
            retire_cnt <= retire_cnt + 32'd1;
            last_wr    <= {write_reg, wb_data};
        end
    end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile: reset clearing, ALU and memory
// writeback, register-0 rules, RegWrite=0 suppression, same-cycle bypass on
// both ports, asynchronous reset, and (with WB_TRACE_EN) the retire trace.
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int BW = 2 + AW + 2 * DW;

    logic          clk;
    logic          clr_n;
    logic [BW-1:0] wb_bus;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic          fwd_valid;
    logic [AW-1:0] fwd_reg;
    logic [DW-1:0] fwd_data;
`ifdef WB_TRACE_EN
    logic [31:0]      retire_cnt;
    logic [AW+DW-1:0] last_wr;
`endif

    int n_checks = 0;
    int n_errors = 0;

    wb_regfile #(
        .DW(DW),
        .AW(AW),
        .BW(BW)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .wb_bus   (wb_bus),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .fwd_valid(fwd_valid),
        .fwd_reg  (fwd_reg),
        .fwd_data (fwd_data)
`ifdef WB_TRACE_EN
        ,
        .retire_cnt(retire_cnt),
        .last_wr   (last_wr)
`endif
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus built by hand: {dmOut, alu_out, writeReg, MemToReg, RegWrite}.
    function automatic logic [BW-1:0] mk_bus(input logic rw, input logic m2r,
                                              input logic [AW-1:0] wr,
                                              input logic [DW-1:0] alu,
                                              input logic [DW-1:0] dm);
        return {dm, alu, wr, m2r, rw};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive bus and read addresses just after a falling edge, then settle.
    task automatic drive(input logic [BW-1:0] b, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        @(negedge clk);
        wb_bus  = b;
        rs_addr = ra;
        rt_addr = rb;
        #1;
    endtask

    task automatic bubble(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        drive('0, ra, rb);
    endtask

    initial begin
        logic [BW-1:0] xbus;

        clr_n   = 1'b0;
        wb_bus  = '0;
        rs_addr = '0;
        rt_addr = '0;
        #12;

        // Reset: every address reads zero on both ports
        for (int i = 0; i < 64; i++) begin
            rs_addr = AW'(i);
            rt_addr = AW'(63 - i);
            #1;
            check("reset_rs", 64'(rs_data), 64'h0);
            check("reset_rt", 64'(rt_data), 64'h0);
        end
        check("reset_fwd_valid", 64'(fwd_valid), 64'h0);

        @(negedge clk);
        clr_n = 1'b1;

        // ALU write to reg 5: bypass before the edge, array value after
        drive(mk_bus(1'b1, 1'b0, 6'd5, 32'h12345678, 32'h0), 6'd5, 6'd0);
        check("alu_bypass_rs", 64'(rs_data), 64'h12345678);
        check("alu_fwd_valid", 64'(fwd_valid), 64'h1);
        check("alu_fwd_reg", 64'(fwd_reg), 64'd5);
        check("alu_fwd_data", 64'(fwd_data), 64'h12345678);
        bubble(6'd5, 6'd0);
        check("alu_commit_rs", 64'(rs_data), 64'h12345678);
        check("bubble_fwd_valid", 64'(fwd_valid), 64'h0);

        // Memory write to reg 9 selects dmOut
        drive(mk_bus(1'b1, 1'b1, 6'd9, 32'h00000001, 32'hDEADBEEF), 6'd5, 6'd9);
        check("m2r_fwd_valid", 64'(fwd_valid), 64'h1);
        check("m2r_fwd_reg", 64'(fwd_reg), 64'd9);
        check("m2r_fwd_data", 64'(fwd_data), 64'hDEADBEEF);
        check("m2r_bypass_rt", 64'(rt_data), 64'hDEADBEEF);
        check("m2r_other_rs", 64'(rs_data), 64'h12345678);
        bubble(6'd9, 6'd9);
        check("m2r_commit_rs", 64'(rs_data), 64'hDEADBEEF);
        check("m2r_commit_rt", 64'(rt_data), 64'hDEADBEEF);

        // Write to reg 0 is dropped and never forwarded
        drive(mk_bus(1'b1, 1'b0, 6'd0, 32'hFFFFFFFF, 32'h0), 6'd0, 6'd0);
        check("r0_fwd_valid", 64'(fwd_valid), 64'h0);
        check("r0_bypass_rs", 64'(rs_data), 64'h0);
        bubble(6'd0, 6'd0);
        check("r0_commit_rs", 64'(rs_data), 64'h0);

        // RegWrite=0 with unknown data fields: no write, no forward
        xbus = mk_bus(1'b0, 1'b1, 6'd7, 32'h000000AA, 32'hDEADBEEF);
        xbus[BW-1 -: DW] = 'x;
        drive(xbus, 6'd7, 6'd7);
        check("rw0_fwd_valid", 64'(fwd_valid), 64'h0);
        check("rw0_no_bypass", 64'(rs_data), 64'h0);
        bubble(6'd7, 6'd5);
        check("rw0_reg7", 64'(rs_data), 64'h0);
        check("rw0_reg5_kept", 64'(rt_data), 64'h12345678);

        // Back-to-back writes to reg 3; both ports bypass the second value
        drive(mk_bus(1'b1, 1'b0, 6'd3, 32'h11, 32'h0), 6'd0, 6'd0);
        drive(mk_bus(1'b1, 1'b0, 6'd3, 32'h22, 32'h0), 6'd3, 6'd3);
        check("b2b_bypass_rs", 64'(rs_data), 64'h22);
        check("b2b_bypass_rt", 64'(rt_data), 64'h22);
        bubble(6'd3, 6'd3);
        check("b2b_commit_rs", 64'(rs_data), 64'h22);
        check("b2b_commit_rt", 64'(rt_data), 64'h22);

        // Asynchronous reset mid-cycle clears reads before the next edge
        bubble(6'd5, 6'd9);
        #2;
        clr_n = 1'b0;
        #1;
        check("async_rst_rs", 64'(rs_data), 64'h0);
        check("async_rst_rt", 64'(rt_data), 64'h0);

        // Write presented during reset is lost
        drive(mk_bus(1'b1, 1'b0, 6'd12, 32'h77, 32'h0), 6'd12, 6'd3);
        check("rst_write_bypass", 64'(rs_data), 64'h77);
        bubble(6'd12, 6'd3);
        check("rst_write_lost", 64'(rs_data), 64'h0);
        check("rst_reg3_clear", 64'(rt_data), 64'h0);

        // First write after release lands on the first rising edge
        drive(mk_bus(1'b1, 1'b0, 6'd12, 32'h55, 32'h0), 6'd1, 6'd1);
        clr_n = 1'b1;
        bubble(6'd12, 6'd1);
        check("post_rst_write", 64'(rs_data), 64'h55);

`ifdef WB_TRACE_EN
        // Fresh reset, then 10 commits interleaved with 3 bubbles
        @(negedge clk);
        clr_n = 1'b0;
        #1;
        check("trace_rst_cnt", 64'(retire_cnt), 64'h0);
        check("trace_rst_last", 64'(last_wr), 64'h0);
        @(negedge clk);
        clr_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive(mk_bus(1'b1, 1'b0, AW'(i), 32'h100 + 32'(i), 32'h0), 6'd0, 6'd0);
            if (i % 3 == 0) bubble(6'd0, 6'd0);
        end
        bubble(6'd10, 6'd1);
        check("trace_cnt", 64'(retire_cnt), 64'd10);
        check("trace_last", 64'(last_wr), {26'h0, 6'd10, 32'h10A});
        check("trace_reg1", 64'(rt_data), 64'h101);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
